rr_grant_scheduler: RTL

//   Round-robin arbiter sharing one downstream resource among N requesters.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/prio_enc_n.sv | 26 ++
 rtl/rr_grant_scheduler.sv | 106 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant scheduler: default size,
// index width helper, FSM state type and pointer wrap helper.
`timescale 1ns/1ps
package arb_pkg;

    localparam int N_DEF = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Pointer position just past idx, wrapping N-1 back to 0.
    function automatic int ptr_wrap(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// N->W lowest-index priority encoder; valid is set when any input bit is set.
`timescale 1ns/1ps
module prio_enc_n
    import arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] in,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scanning downward lets the lowest set bit overwrite higher ones.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin arbiter issuing one registered grant per cycle under valid/ready.
// Build option: define RR_ARB_LOCK_EN to add the lock port (hold ptr on accept).
`timescale 1ns/1ps
module rr_grant_scheduler
    import arb_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         gnt_ready,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot
`ifdef RR_ARB_LOCK_EN
    ,
    input  logic         lock
`endif
);

    state_t       state, state_d;
    logic [W-1:0] ptr;
    logic [W-1:0] adv_ptr;
    logic [W-1:0] search_ptr;
    logic [N-1:0] mask_ge_ptr;
    logic [W-1:0] masked_idx, full_idx, win_idx;
    logic         masked_valid, full_valid;
    logic         accept, load, hold_ptr;

`ifdef RR_ARB_LOCK_EN
    assign hold_ptr = lock;
`else
    assign hold_ptr = 1'b0;
`endif

    assign accept  = (state == GRANT) && gnt_ready;
    assign adv_ptr = hold_ptr ? ptr : W'(ptr_wrap(32'(gnt_idx), N));

    // On accept the search already sees the advanced pointer, so the
    // just-served requester drops to lowest priority in the same cycle.
    assign search_ptr  = accept ? adv_ptr : ptr;
    assign mask_ge_ptr = {N{1'b1}} << search_ptr;

    prio_enc_n #(.N(N), .W(W)) u_enc_masked (
        .in    (req & mask_ge_ptr),
        .idx   (masked_idx),
        .valid (masked_valid)
    );

    prio_enc_n #(.N(N), .W(W)) u_enc_full (
        .in    (req),
        .idx   (full_idx),
        .valid (full_valid)
    );

    assign win_idx = masked_valid ? masked_idx : full_idx;

    always_comb begin
        state_d = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (en && full_valid) begin
                    state_d = GRANT;
                    load    = 1'b1;
                end
            end
            GRANT: begin
                if (accept) begin
                    if (en && full_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else begin
            state     <= state_d;
            gnt_valid <= (state_d == GRANT);
            if (accept) begin
                ptr <= adv_ptr;
            end
            if (load) begin
                gnt_idx    <= win_idx;
                gnt_onehot <= N'(1) << win_idx;
            end else if (state_d == IDLE) begin
                gnt_onehot <= '0;
            end
        end
    end

endmodule
